// File: rtl/mul_32bit_seq_pkg.sv
// Shared definitions for the sequential shift-and-add multiplier.
// Holds the state encodings, datapath widths and the last-iteration index.
package mul_32bit_seq_pkg;

    localparam int WIDTH = 32;
    localparam int CNT_W = 6;

    typedef logic [1:0] state_t;

    localparam state_t S_IDLE = 2'd0;
    localparam state_t S_RUN  = 2'd1;
    localparam state_t S_DONE = 2'd2;

    localparam logic [CNT_W-1:0] ITER_LAST = 6'd31;

endpackage

// File: rtl/mul_32bit_seq_if.sv
// Start/busy/done handshake and operand/product bus between the ALU control and the multiplier.
interface mul_32bit_seq_if;
    import mul_32bit_seq_pkg::*;

    logic                 i_start;
    logic [WIDTH-1:0]     i_a;
    logic [WIDTH-1:0]     i_b;
    logic                 o_busy;
    logic                 o_done;
    logic [2*WIDTH-1:0]   o_p;

    modport master (
        output i_start,
        output i_a,
        output i_b,
        input  o_busy,
        input  o_done,
        input  o_p
    );

    modport slave (
        input  i_start,
        input  i_a,
        input  i_b,
        output o_busy,
        output o_done,
        output o_p
    );

endinterface

// File: rtl/mul_32bit_seq_add_32bit.sv
// Fixed-width 32-bit adder with carry in/out, used as the multiplier's datapath adder.
module add_32bit (
    input  logic [31:0] i_x,
    input  logic [31:0] i_y,
    input  logic        i_c_in,
    output logic [31:0] o_z,
    output logic        o_c_out
);

    logic [32:0] w_sum;

    assign w_sum   = {1'b0, i_x} + {1'b0, i_y} + {32'd0, i_c_in};
    assign o_z     = w_sum[31:0];
    assign o_c_out = w_sum[32];

endmodule

// File: rtl/mul_32bit_seq.sv
// Sequential unsigned 32x32->64 shift-and-add multiplier, one iteration per cycle.
// The accumulator and multiplier shift right together so {ACC, Q} ends up holding the product.
module mul_32bit_seq
    import mul_32bit_seq_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    mul_32bit_seq_if.slave    bus
);

    state_t               r_state;
    state_t               w_next_state;
    logic [WIDTH-1:0]     r_acc;
    logic [WIDTH-1:0]     r_q;
    logic [WIDTH-1:0]     r_m;
    logic [CNT_W-1:0]     r_count;
    logic [2*WIDTH-1:0]   r_p;

    logic                 w_accept;
    logic                 w_iter;
    logic                 w_last;
    logic [WIDTH-1:0]     w_y;
    logic [WIDTH-1:0]     w_z;
    logic                 w_c_out;
    logic [WIDTH-1:0]     w_acc_next;
    logic [WIDTH-1:0]     w_q_next;

    assign w_accept = ((r_state == S_IDLE) || (r_state == S_DONE)) && bus.i_start;
    assign w_iter   = (r_state == S_RUN);
    assign w_last   = w_iter && (r_count == ITER_LAST);

    assign w_y = r_q[0] ? r_m : '0;

    add_32bit u_add (
        .i_x     (r_acc),
        .i_y     (w_y),
        .i_c_in  (1'b0),
        .o_z     (w_z),
        .o_c_out (w_c_out)
    );

    // Carry-out becomes the new accumulator MSB so no product bit is ever lost.
    assign w_acc_next = {w_c_out, w_z[WIDTH-1:1]};
    assign w_q_next   = {w_z[0], r_q[WIDTH-1:1]};

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  w_next_state = bus.i_start ? S_RUN : S_IDLE;
            S_RUN:   w_next_state = w_last ? S_DONE : S_RUN;
            S_DONE:  w_next_state = bus.i_start ? S_RUN : S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_acc   <= '0;
            r_q     <= '0;
            r_m     <= '0;
            r_count <= '0;
        end else if (w_accept) begin
            r_acc   <= '0;
            r_q     <= bus.i_b;
            r_m     <= bus.i_a;
            r_count <= '0;
        end else if (w_iter) begin
            r_acc   <= w_acc_next;
            r_q     <= w_q_next;
            r_count <= r_count + 1'b1;
        end
    end

    // The product register only changes on completion, so it holds across a back-to-back start.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_p <= '0;
        end else if (w_last) begin
            r_p <= {w_acc_next, w_q_next};
        end
    end

    assign bus.o_busy = (r_state == S_RUN);
    assign bus.o_done = (r_state == S_DONE);
    assign bus.o_p    = r_p;

endmodule

// File: tb/tb_mul_32bit_seq.sv
// Directed and random checks of the sequential multiplier's handshake, latency and products.
module tb_mul_32bit_seq;

    logic clk;
    logic rst_n;
    int   nChecks;
    int   nFails;

    mul_32bit_seq_if bus ();

    mul_32bit_seq dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] p;
        bit          disturb;
    } vec_t;

    vec_t vecs[8];

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, input bit st);
        bus.i_a     = a;
        bus.i_b     = b;
        bus.i_start = st;
    endtask

    // One full operation from IDLE; optionally pokes START and new operands mid-run.
    task automatic runOp(input string name, input logic [31:0] a, input logic [31:0] b,
                         input logic [63:0] exp, input bit disturb);
        int busyCnt;
        int doneAt;
        int doneCnt;
        logic [63:0] pAtDone;
        busyCnt = 0;
        doneAt  = 0;
        doneCnt = 0;
        pAtDone = '0;
        applyStimulus(a, b, 1'b1);
        @(negedge clk);
        bus.i_start = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            if (bus.o_busy) busyCnt++;
            if (bus.o_done) begin
                doneCnt++;
                if (doneAt == 0) begin
                    doneAt  = k;
                    pAtDone = bus.o_p;
                end
            end
            if (disturb && k == 5) applyStimulus(32'hDEAD_BEEF, 32'h1234_0001, 1'b1);
            if (disturb && k == 6) bus.i_start = 1'b0;
            @(negedge clk);
        end
        checkOutput({name, " busyCycles"}, 64'(busyCnt), 64'd32);
        checkOutput({name, " doneCycle"}, 64'(doneAt), 64'd33);
        checkOutput({name, " doneCount"}, 64'(doneCnt), 64'd1);
        checkOutput({name, " P"}, pAtDone, exp);
        checkOutput({name, " Pheld"}, bus.o_p, exp);
    endtask

    task automatic doReset();
        rst_n = 1'b0;
        applyStimulus(32'h0, 32'h0, 1'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int doneAt;
        logic [63:0] exp;
        logic [31:0] ra;
        logic [31:0] rb;
        nChecks = 0;
        nFails  = 0;
        rst_n   = 1'b0;
        applyStimulus(32'h0, 32'h0, 1'b0);

        vecs[0] = '{"3x5",        32'h0000_0003, 32'h0000_0005, 64'h0000_0000_0000_000F, 1'b0};
        vecs[1] = '{"allOnes",    32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 1'b0};
        vecs[2] = '{"msbx2",      32'h8000_0000, 32'h0000_0002, 64'h0000_0001_0000_0000, 1'b0};
        vecs[3] = '{"timesZero",  32'h7FFF_FFFF, 32'h0000_0000, 64'h0000_0000_0000_0000, 1'b0};
        vecs[4] = '{"disturbed",  32'h7FFF_FFFF, 32'h7FFF_FFFF, 64'h3FFF_FFFF_0000_0001, 1'b1};
        vecs[5] = '{"onesx1",     32'hFFFF_FFFF, 32'h0000_0001, 64'h0000_0000_FFFF_FFFF, 1'b0};
        vecs[6] = '{"1x1",        32'h0000_0001, 32'h0000_0001, 64'h0000_0000_0000_0001, 1'b0};
        vecs[7] = '{"mixed",      32'h1234_5678, 32'h9ABC_DEF0, 64'h0B00_EA4E_242D_2080, 1'b0};

        @(negedge clk);
        doReset();
        for (int i = 0; i < 10; i++) begin
            checkOutput("idleBusy", 64'(bus.o_busy), 64'd0);
            checkOutput("idleDone", 64'(bus.o_done), 64'd0);
            checkOutput("idleP", bus.o_p, 64'd0);
            @(negedge clk);
        end

        for (int i = 0; i < 8; i++) begin
            runOp(vecs[i].name, vecs[i].a, vecs[i].b, vecs[i].p, vecs[i].disturb);
        end

        // Back-to-back: START held in the DONE cycle starts the next multiply without an IDLE gap
        applyStimulus(32'h0000_0003, 32'h0000_0005, 1'b1);
        @(negedge clk);
        bus.i_start = 1'b0;
        repeat (32) @(negedge clk);
        checkOutput("b2bDone1", 64'(bus.o_done), 64'd1);
        checkOutput("b2bP1", bus.o_p, 64'h0000_0000_0000_000F);
        applyStimulus(32'h8000_0000, 32'h0000_0002, 1'b1);
        @(negedge clk);
        bus.i_start = 1'b0;
        checkOutput("b2bNoGap", 64'(bus.o_busy), 64'd1);
        checkOutput("b2bPkept", bus.o_p, 64'h0000_0000_0000_000F);
        repeat (32) @(negedge clk);
        checkOutput("b2bDone2", 64'(bus.o_done), 64'd1);
        checkOutput("b2bP2", bus.o_p, 64'h0000_0001_0000_0000);
        @(negedge clk);

        // Reset at iteration 10 aborts the multiply; reset also beats a simultaneous START
        applyStimulus(32'h1234_5678, 32'h9ABC_DEF0, 1'b1);
        @(negedge clk);
        bus.i_start = 1'b0;
        repeat (9) @(negedge clk);
        checkOutput("midBusyBefore", 64'(bus.o_busy), 64'd1);
        rst_n = 1'b0;
        bus.i_start = 1'b1;
        @(negedge clk);
        checkOutput("rstBusy", 64'(bus.o_busy), 64'd0);
        checkOutput("rstDone", 64'(bus.o_done), 64'd0);
        checkOutput("rstP", bus.o_p, 64'd0);
        @(negedge clk);
        checkOutput("rstWinsBusy", 64'(bus.o_busy), 64'd0);
        rst_n = 1'b1;
        bus.i_start = 1'b0;
        @(negedge clk);
        runOp("afterReset", 32'h1234_5678, 32'h9ABC_DEF0, 64'h0B00_EA4E_242D_2080, 1'b0);

        // Random back-to-back operations with START held high throughout
        ra = $urandom;
        rb = $urandom;
        applyStimulus(ra, rb, 1'b1);
        exp = {32'd0, ra} * {32'd0, rb};
        for (int n = 0; n < 1000; n++) begin
            @(negedge clk);
            ra = $urandom;
            rb = $urandom;
            bus.i_a = ra;
            bus.i_b = rb;
            doneAt = 0;
            for (int k = 1; k <= 40 && doneAt == 0; k++) begin
                if (bus.o_done) doneAt = k;
                else @(negedge clk);
            end
            checkOutput("rndDoneCycle", 64'(doneAt), 64'd33);
            checkOutput("rndP", bus.o_p, exp);
            exp = {32'd0, ra} * {32'd0, rb};
        end
        bus.i_start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checkOutput("rndSingleDone", 64'(bus.o_done), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
